mem_arbiter: RTL and testbench

// - Sits between three memory requesters (instruction fetch, load, store) and the single

---
 rtl/mem_arbiter_pkg.sv | 43 ++++
 rtl/mem_arb_pick.sv | 43 ++++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared codes and helpers for the memory arbiter
// Purpose: enable/direction codes, port ids, FSM states, idle field values,
//          access length codes and the read-data length mask.
// Ports:   none (package).
package mem_arbiter_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [31:0] ADDR_FREE = 32'h0000_0000;
  localparam logic [31:0] DATA_FREE = 32'h0000_0000;

  // Length codes are bytes-1.
  localparam logic [1:0] LEN_BYTE   = 2'b00;
  localparam logic [1:0] LEN_HALF   = 2'b01;
  localparam logic [1:0] LEN_TRIPLE = 2'b10;
  localparam logic [1:0] LEN_WORD   = 2'b11;

  typedef enum logic [1:0] {
    PORT_IF = 2'd0,
    PORT_LD = 2'd1,
    PORT_ST = 2'd2
  } port_id_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Keeps only the bytes a read of the given length actually returned.
  function automatic logic [31:0] len_mask(input logic [1:0] len);
    case (len)
      LEN_BYTE:   return 32'h0000_00FF;
      LEN_HALF:   return 32'h0000_FFFF;
      LEN_TRIPLE: return 32'h00FF_FFFF;
      default:    return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational three-way priority picker with IF ageing
// Purpose: chooses one of the pending requesters: store over load over fetch,
//          unless fetch has aged past the limit, then fetch goes first.
// Ports:   req_if/req_ld/req_st - pending flags
//          age                  - number of grants fetch has been passed over
//          grant                - one-hot grant {st, ld, if}
//          id                   - port id of the grant
//          any                  - at least one request pending
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int AGE_LIMIT = 4,
  parameter int AGE_W     = 3
) (
  input  logic             req_if,
  input  logic             req_ld,
  input  logic             req_st,
  input  logic [AGE_W-1:0] age,
  output logic [2:0]       grant,
  output port_id_e         id,
  output logic             any
);

  always_comb begin
    grant = 3'b000;
    id    = PORT_IF;
    any   = req_if | req_ld | req_st;
    if (req_if && (age >= AGE_W'(AGE_LIMIT))) begin
      grant = 3'b001;
      id    = PORT_IF;
    end else if (req_st) begin
      grant = 3'b100;
      id    = PORT_ST;
    end else if (req_ld) begin
      grant = 3'b010;
      id    = PORT_LD;
    end else if (req_if) begin
      grant = 3'b001;
      id    = PORT_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-port arbiter in front of the byte-serial memory controller
// Purpose: buffers one fetch, one load and one store request, issues one at a
//          time to the controller and returns each completion to its owner.
// Ports:   clk, rst (async, active high)
//          ifEn/ifAddr/ifFlush -> ifFree, ifDone, ifData   instruction fetch
//          ldEn/ldAddr/ldLen   -> ldFree, ldDone, ldData   load
//          stEn/stAddr/stLen/stData -> stFree, stDone      store
//          mEn/mRW/mAddr/mLen/mWdata -> controller issue; mDone/mRdata <- completion
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AGE_LIMIT = 4,
  parameter int AGE_W     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifEn,
  input  logic [31:0] ifAddr,
  input  logic        ifFlush,
  output logic        ifFree,
  output logic        ifDone,
  output logic [31:0] ifData,
  input  logic        ldEn,
  input  logic [31:0] ldAddr,
  input  logic [1:0]  ldLen,
  output logic        ldFree,
  output logic        ldDone,
  output logic [31:0] ldData,
  input  logic        stEn,
  input  logic [31:0] stAddr,
  input  logic [1:0]  stLen,
  input  logic [31:0] stData,
  output logic        stFree,
  output logic        stDone,
  output logic        mEn,
  output logic        mRW,
  output logic [31:0] mAddr,
  output logic [1:0]  mLen,
  output logic [31:0] mWdata,
  input  logic        mDone,
  input  logic [31:0] mRdata
);

  arb_state_e       state;
  port_id_e         owner;
  logic             if_occ, ld_occ, st_occ;
  // Set when the fetch currently at the controller was flushed; its
  // completion is then swallowed and the IF slot may already hold a new one.
  logic             if_killed;
  logic [31:0]      if_addr_q, ld_addr_q, st_addr_q, st_data_q;
  logic [1:0]       ld_len_q, st_len_q;
  logic [AGE_W-1:0] age;

  logic [2:0]       grant;
  port_id_e         pick_id;
  logic             pick_any;

  assign ifFree = ~if_occ;
  assign ldFree = ~ld_occ;
  assign stFree = ~st_occ;

  // A fetch being flushed this edge must not be picked on the same edge.
  mem_arb_pick #(
    .AGE_LIMIT(AGE_LIMIT),
    .AGE_W    (AGE_W)
  ) u_pick (
    .req_if(if_occ & ~ifFlush),
    .req_ld(ld_occ),
    .req_st(st_occ),
    .age   (age),
    .grant (grant),
    .id    (pick_id),
    .any   (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= PORT_IF;
      if_occ    <= DISABLE;
      ld_occ    <= DISABLE;
      st_occ    <= DISABLE;
      if_killed <= DISABLE;
      if_addr_q <= ADDR_FREE;
      ld_addr_q <= ADDR_FREE;
      st_addr_q <= ADDR_FREE;
      st_data_q <= DATA_FREE;
      ld_len_q  <= LEN_BYTE;
      st_len_q  <= LEN_BYTE;
      age       <= '0;
      ifDone    <= DISABLE;
      ldDone    <= DISABLE;
      stDone    <= DISABLE;
      ifData    <= DATA_FREE;
      ldData    <= DATA_FREE;
      mEn       <= DISABLE;
      mRW       <= MEM_READ;
      mAddr     <= ADDR_FREE;
      mLen      <= LEN_BYTE;
      mWdata    <= DATA_FREE;
    end else begin
      ifDone <= DISABLE;
      ldDone <= DISABLE;
      stDone <= DISABLE;
      mEn    <= DISABLE;

      // Slot capture. Flush beats a simultaneous fetch request.
      if (ifFlush) begin
        if_occ <= DISABLE;
        if (state == ST_BUSY && owner == PORT_IF) if_killed <= ENABLE;
      end else if (ifEn && !if_occ) begin
        if_occ    <= ENABLE;
        if_addr_q <= ifAddr;
      end
      if (ldEn && !ld_occ) begin
        ld_occ    <= ENABLE;
        ld_addr_q <= ldAddr;
        ld_len_q  <= ldLen;
      end
      if (stEn && !st_occ) begin
        st_occ    <= ENABLE;
        st_addr_q <= stAddr;
        st_len_q  <= stLen;
        st_data_q <= stData;
      end

      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            mEn   <= ENABLE;
            owner <= pick_id;
            state <= ST_BUSY;
            if (grant[2]) begin
              mRW    <= MEM_WRITE;
              mAddr  <= st_addr_q;
              mLen   <= st_len_q;
              mWdata <= st_data_q;
            end else if (grant[1]) begin
              mRW    <= MEM_READ;
              mAddr  <= ld_addr_q;
              mLen   <= ld_len_q;
              mWdata <= DATA_FREE;
            end else begin
              mRW    <= MEM_READ;
              mAddr  <= if_addr_q;
              mLen   <= LEN_WORD;
              mWdata <= DATA_FREE;
            end
            // Age saturates at the limit rather than wrapping.
            if (grant[0]) begin
              age <= '0;
            end else if (if_occ && !ifFlush && (age < AGE_W'(AGE_LIMIT))) begin
              age <= age + 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (mDone) begin
            state     <= ST_IDLE;
            if_killed <= DISABLE;
            case (owner)
              PORT_ST: begin
                stDone <= ENABLE;
                st_occ <= DISABLE;
              end
              PORT_LD: begin
                ldDone <= ENABLE;
                ldData <= mRdata & len_mask(ld_len_q);
                ld_occ <= DISABLE;
              end
              default: begin
                if (!if_killed && !ifFlush) begin
                  ifDone <= ENABLE;
                  ifData <= mRdata;
                  if_occ <= DISABLE;
                end
              end
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifEn = 1'b0, ifFlush = 1'b0, ldEn = 1'b0, stEn = 1'b0, mDone = 1'b0;
  logic [31:0] ifAddr = '0, ldAddr = '0, stAddr = '0, stData = '0, mRdata = '0;
  logic [1:0]  ldLen = '0, stLen = '0;
  logic        ifFree, ifDone, ldFree, ldDone, stFree, stDone, mEn, mRW;
  logic [31:0] ifData, ldData, mAddr, mWdata;
  logic [1:0]  mLen;

  int checks = 0;
  int errors = 0;
  int grants;
  int if_at;

  always #5 clk = ~clk;

  mem_arbiter #(.AGE_LIMIT(4), .AGE_W(3)) dut (
    .clk(clk), .rst(rst),
    .ifEn(ifEn), .ifAddr(ifAddr), .ifFlush(ifFlush),
    .ifFree(ifFree), .ifDone(ifDone), .ifData(ifData),
    .ldEn(ldEn), .ldAddr(ldAddr), .ldLen(ldLen),
    .ldFree(ldFree), .ldDone(ldDone), .ldData(ldData),
    .stEn(stEn), .stAddr(stAddr), .stLen(stLen), .stData(stData),
    .stFree(stFree), .stDone(stDone),
    .mEn(mEn), .mRW(mRW), .mAddr(mAddr), .mLen(mLen), .mWdata(mWdata),
    .mDone(mDone), .mRdata(mRdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle completion from the controller.
  task automatic serve(input logic [31:0] d);
    mDone  = 1'b1;
    mRdata = d;
    tick();
    mDone  = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_iffree", ifFree, 1);
    check("rst_ldfree", ldFree, 1);
    check("rst_stfree", stFree, 1);
    check("rst_men", mEn, 0);
    check("rst_maddr", mAddr, 0);
    check("rst_done", {ifDone, ldDone, stDone}, 0);
    rst = 1'b0;
    tick();

    // Lone IF, completion 4 cycles after issue
    ifEn = 1'b1; ifAddr = 32'h100;
    tick();
    ifEn = 1'b0;
    check("if_accept_free", ifFree, 0);
    check("if_accept_men", mEn, 0);
    tick();
    check("if_issue_men", mEn, 1);
    check("if_issue_addr", mAddr, 32'h100);
    check("if_issue_len", mLen, 2'b11);
    check("if_issue_rw", mRW, 0);
    tick();
    check("if_men_pulse", mEn, 0);
    tick(); tick(); tick();
    serve(32'hDEADBEEF);
    check("if_done", ifDone, 1);
    check("if_data", ifData, 32'hDEADBEEF);
    check("if_free_again", ifFree, 1);
    tick();
    check("if_done_pulse", ifDone, 0);

    // Three requests on one edge: ST, LD, IF
    ifEn = 1'b1; ifAddr = 32'h400;
    ldEn = 1'b1; ldAddr = 32'h500; ldLen = 2'b01;
    stEn = 1'b1; stAddr = 32'h600; stLen = 2'b11; stData = 32'hA5A55A5A;
    tick();
    ifEn = 1'b0; ldEn = 1'b0; stEn = 1'b0;
    tick();
    check("p1_men", mEn, 1);
    check("p1_rw", mRW, 1);
    check("p1_addr", mAddr, 32'h600);
    check("p1_wdata", mWdata, 32'hA5A55A5A);
    serve(32'h0);
    check("p1_done", {ifDone, ldDone, stDone}, 3'b001);
    check("p1_idle_men", mEn, 0);
    tick();
    check("p2_men", mEn, 1);
    check("p2_rw", mRW, 0);
    check("p2_addr", mAddr, 32'h500);
    check("p2_len", mLen, 2'b01);
    check("p2_wdata", mWdata, 0);
    serve(32'hCAFEF00D);
    check("p2_done", {ifDone, ldDone, stDone}, 3'b010);
    check("p2_lddata", ldData, 32'h0000F00D);
    tick();
    check("p3_men", mEn, 1);
    check("p3_addr", mAddr, 32'h400);
    check("p3_len", mLen, 2'b11);
    serve(32'h0BADF00D);
    check("p3_done", {ifDone, ldDone, stDone}, 3'b100);
    check("p3_ifdata", ifData, 32'h0BADF00D);

    // Byte load masking
    tick();
    ldEn = 1'b1; ldAddr = 32'h700; ldLen = 2'b00;
    tick();
    ldEn = 1'b0;
    tick();
    check("lb_men", mEn, 1);
    check("lb_len", mLen, 2'b00);
    serve(32'h123456AB);
    check("lb_data", ldData, 32'h000000AB);

    // Ageing: IF held off by continuously refilled LD/ST
    tick();
    mRdata = 32'h11112222;
    ifEn = 1'b1; ifAddr = 32'h800;
    ldEn = 1'b1; ldAddr = 32'h804; ldLen = 2'b11;
    stEn = 1'b1; stAddr = 32'h808; stLen = 2'b11; stData = 32'h5;
    tick();
    ifEn = 1'b0;
    grants = 0;
    if_at = 0;
    for (int c = 0; c < 40 && if_at == 0; c++) begin
      ldEn  = ldFree;
      stEn  = stFree;
      mDone = mEn;
      if (mEn) begin
        grants++;
        if (mAddr == 32'h800) if_at = grants;
      end
      if (if_at == 0) tick();
    end
    check("age_if_grant", if_at, 5);
    ldEn = 1'b0; stEn = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      mDone = mEn;
    end
    mDone = 1'b0;
    check("age_drain_free", {ifFree, ldFree, stFree}, 3'b111);
    check("age_ifdata", ifData, 32'h11112222);

    // Flush together with a new request: flush wins
    ifEn = 1'b1; ifFlush = 1'b1; ifAddr = 32'hA00;
    tick();
    ifEn = 1'b0; ifFlush = 1'b0;
    check("flen_free", ifFree, 1);
    tick();
    check("flen_men", mEn, 0);

    // Flush while IF is in flight
    ifEn = 1'b1; ifAddr = 32'h200;
    tick();
    ifEn = 1'b0;
    tick();
    check("fl_issue", mEn, 1);
    check("fl_issue_addr", mAddr, 32'h200);
    ldEn = 1'b1; ldAddr = 32'h300; ldLen = 2'b11; ifFlush = 1'b1;
    tick();
    ldEn = 1'b0; ifFlush = 1'b0;
    check("fl_iffree", ifFree, 1);
    check("fl_busy_men", mEn, 0);
    serve(32'h55);
    check("fl_no_ifdone", ifDone, 0);
    check("fl_ifdata_kept", ifData, 32'h11112222);
    check("fl_idle_gap", mEn, 0);
    tick();
    check("fl_ld_issue", mEn, 1);
    check("fl_ld_addr", mAddr, 32'h300);
    serve(32'h77);
    check("fl_ld_done", ldDone, 1);
    check("fl_ld_data", ldData, 32'h77);

    // Reset while BUSY, then a stray completion
    tick();
    stEn = 1'b1; stAddr = 32'h900; stLen = 2'b11; stData = 32'h99;
    tick();
    stEn = 1'b0;
    tick();
    check("rb_issue", mEn, 1);
    tick();
    rst = 1'b1;
    #1;
    check("rb_free", {ifFree, ldFree, stFree}, 3'b111);
    check("rb_mfields", {mEn, mRW, mLen}, 0);
    check("rb_maddr", mAddr, 0);
    check("rb_mwdata", mWdata, 0);
    check("rb_ifdata", ifData, 0);
    check("rb_lddata", ldData, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mDone = 1'b1; mRdata = 32'hFFFF;
    tick();
    mDone = 1'b0;
    check("rb_stray_done", {ifDone, ldDone, stDone}, 0);
    check("rb_stray_men", mEn, 0);
    tick();
    check("rb_after_men", mEn, 0);
    check("rb_after_lddata", ldData, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
